// File: rtl/fx_bus_master.sv
// Host byte-stream command parser driving single-cycle fx register bus writes and reads.
// Read data is returned one byte per transaction on the response stream.
module fx_bus_master #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    output logic [7:0]  rsp_data,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [21:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic [21:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic        busy,
    output logic        err_cmd
);

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned LAT_W  = 2;
    localparam logic [7:0]  OP_WR  = 8'h01;
    localparam logic [7:0]  OP_RD  = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_ADR2, S_ADR1, S_ADR0, S_LEN, S_WDAT, S_WR, S_RD, S_RWAIT, S_RSP
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [LAT_W-1:0]    r_lat;
    logic                r_is_wr;
    logic                r_cmd_rdy;
    logic [7:0]          r_rsp_data;
    logic                r_rsp_vld;
    logic [ADDR_W-1:0]   r_fx_waddr;
    logic                r_fx_wr;
    logic [7:0]          r_fx_data;
    logic [ADDR_W-1:0]   r_fx_raddr;
    logic                r_fx_rd;
    logic                r_busy;
    logic                r_err;

    logic                w_acc;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_acc      = cmd_vld & r_cmd_rdy;
    assign w_last     = (r_cnt == CNT_W'(1));
    // Increment wraps inside the device's 64K window; the device id is fixed.
    assign w_addr_inc = {r_addr[21:16], r_addr[15:0] + 16'd1};

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_lat      <= '0;
            r_is_wr    <= 1'b0;
            r_cmd_rdy  <= 1'b1;
            r_rsp_data <= 8'h00;
            r_rsp_vld  <= 1'b0;
            r_fx_waddr <= '0;
            r_fx_wr    <= 1'b0;
            r_fx_data  <= 8'h00;
            r_fx_raddr <= '0;
            r_fx_rd    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_fx_wr <= 1'b0;
            r_fx_rd <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    if (cmd_data == OP_WR || cmd_data == OP_RD) begin
                        r_is_wr <= (cmd_data == OP_WR);
                        r_busy  <= 1'b1;
                        r_state <= S_ADR2;
                    end else begin
                        r_err   <= 1'b1;
                    end
                end
                S_ADR2: if (w_acc) begin
                    r_addr[21:16] <= cmd_data[5:0];
                    r_state       <= S_ADR1;
                end
                S_ADR1: if (w_acc) begin
                    r_addr[15:8] <= cmd_data;
                    r_state      <= S_ADR0;
                end
                S_ADR0: if (w_acc) begin
                    r_addr[7:0] <= cmd_data;
                    r_state     <= S_LEN;
                end
                S_LEN: if (w_acc) begin
                    r_cnt <= CNT_W'(cmd_data) + CNT_W'(1);
                    if (r_is_wr) begin
                        r_state    <= S_WDAT;
                    end else begin
                        r_fx_rd    <= 1'b1;
                        r_fx_raddr <= r_addr;
                        r_cmd_rdy  <= 1'b0;
                        r_state    <= S_RD;
                    end
                end
                S_WDAT: if (w_acc) begin
                    r_fx_wr    <= 1'b1;
                    r_fx_waddr <= r_addr;
                    r_fx_data  <= cmd_data;
                    r_cmd_rdy  <= 1'b0;
                    r_state    <= S_WR;
                end
                S_WR: begin
                    r_addr    <= w_addr_inc;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    r_cmd_rdy <= 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WDAT;
                    end
                end
                S_RD: begin
                    r_lat   <= '0;
                    r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (r_lat == LAT_W'(RD_LAT - 1)) begin
                        r_rsp_data <= fx_q;
                        r_rsp_vld  <= 1'b1;
                        r_state    <= S_RSP;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                S_RSP: if (rsp_rdy) begin
                    r_rsp_vld <= 1'b0;
                    r_addr    <= w_addr_inc;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_busy    <= 1'b0;
                        r_cmd_rdy <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_fx_rd    <= 1'b1;
                        r_fx_raddr <= w_addr_inc;
                        r_state    <= S_RD;
                    end
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_cmd_rdy <= 1'b1;
                    r_rsp_vld <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_rdy  = r_cmd_rdy;
    assign rsp_data = r_rsp_data;
    assign rsp_vld  = r_rsp_vld;
    assign fx_waddr = r_fx_waddr;
    assign fx_wr    = r_fx_wr;
    assign fx_data  = r_fx_data;
    assign fx_raddr = r_fx_raddr;
    assign fx_rd    = r_fx_rd;
    assign busy     = r_busy;
    assign err_cmd  = r_err;

endmodule

// File: tb/tb_fx_bus_master.sv
// Directed bench for fx_bus_master: command packets in, fx bus and response stream checked
// against hand-computed addresses, data and cycle timing.
module tb_fx_bus_master;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [7:0]  rsp_data;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b1;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q = 8'h00;
    logic        busy;
    logic        err_cmd;

    int vectors = 0;
    int miscompares = 0;

    int          cyc = 0;
    logic [21:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_cyc_q[$];
    logic [21:0] rd_addr_q[$];
    int          err_cnt = 0;
    int          both_cnt = 0;

    fx_bus_master #(.RD_LAT(1)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .cmd_data(cmd_data),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .rsp_data(rsp_data),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .fx_waddr(fx_waddr),
        .fx_wr   (fx_wr),
        .fx_data (fx_data),
        .fx_raddr(fx_raddr),
        .fx_rd   (fx_rd),
        .fx_q    (fx_q),
        .busy    (busy),
        .err_cmd (err_cmd)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Slave: data valid the cycle after fx_rd, zero when not selected.
    function automatic logic [7:0] slave_val(input logic [21:0] a);
        if (a == 22'h010081) return 8'hA5;
        return a[7:0] + 8'h10;
    endfunction

    always @(posedge clk_sys) fx_q <= fx_rd ? slave_val(fx_raddr) : 8'h00;

    always @(negedge clk_sys) begin
        if (fx_wr === 1'b1) begin
            wr_addr_q.push_back(fx_waddr);
            wr_data_q.push_back(fx_data);
            wr_cyc_q.push_back(cyc);
        end
        if (fx_rd === 1'b1) rd_addr_q.push_back(fx_raddr);
        if (err_cmd === 1'b1) err_cnt++;
        if (fx_wr === 1'b1 && fx_rd === 1'b1) both_cnt++;
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rd_addr_q.delete();
        err_cnt = 0;
    endtask

    // Offers one byte and returns at posedge+1 of the cycle after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data = b;
        cmd_vld  = 1'b1;
        @(negedge clk_sys);
        while (cmd_rdy !== 1'b1 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL send_byte_timeout: cmd_rdy=%b required 1 (byte %h)", cmd_rdy, b);
        end
        @(posedge clk_sys);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        @(negedge clk_sys);
        vectors++; if (fx_wr !== 1'b0) begin miscompares++; $display("FAIL reset_fx_wr: got %b required 0", fx_wr); end
        vectors++; if (fx_rd !== 1'b0) begin miscompares++; $display("FAIL reset_fx_rd: got %b required 0", fx_rd); end
        vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_vld: got %b required 0", rsp_vld); end
        vectors++; if (err_cmd !== 1'b0) begin miscompares++; $display("FAIL reset_err_cmd: got %b required 0", err_cmd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
        vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_rdy: got %b required 1", cmd_rdy); end
        vectors++; if (fx_waddr !== 22'h0) begin miscompares++; $display("FAIL reset_fx_waddr: got %h required 000000", fx_waddr); end
        vectors++; if (fx_raddr !== 22'h0) begin miscompares++; $display("FAIL reset_fx_raddr: got %h required 000000", fx_raddr); end
        vectors++; if (fx_data !== 8'h0) begin miscompares++; $display("FAIL reset_fx_data: got %h required 00", fx_data); end
        vectors++; if (rsp_data !== 8'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h required 00", rsp_data); end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_single_write();
        clear_log();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h80); send_byte(8'h00);
        send_byte(8'h3C);
        @(negedge clk_sys);
        vectors++; if (fx_wr !== 1'b1) begin miscompares++; $display("FAIL wr1_strobe: got %b required 1", fx_wr); end
        vectors++; if (fx_waddr !== 22'h010080) begin miscompares++; $display("FAIL wr1_addr: got %h required 010080", fx_waddr); end
        vectors++; if (fx_data !== 8'h3C) begin miscompares++; $display("FAIL wr1_data: got %h required 3c", fx_data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr1_busy_during: got %b required 1", busy); end
        @(negedge clk_sys);
        vectors++; if (fx_wr !== 1'b0) begin miscompares++; $display("FAIL wr1_strobe_end: got %b required 0", fx_wr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr1_busy_after: got %b required 0", busy); end
        vectors++; if (fx_waddr !== 22'h010080) begin miscompares++; $display("FAIL wr1_addr_hold: got %h required 010080", fx_waddr); end
        idle_cycles(3);
        vectors++; if (wr_addr_q.size() !== 1) begin miscompares++; $display("FAIL wr1_count: got %0d required 1", wr_addr_q.size()); end
    endtask

    task automatic test_single_read();
        clear_log();
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h00); send_byte(8'h81); send_byte(8'h00);
        @(negedge clk_sys);
        vectors++; if (fx_rd !== 1'b1) begin miscompares++; $display("FAIL rd1_strobe: got %b required 1", fx_rd); end
        vectors++; if (fx_raddr !== 22'h010081) begin miscompares++; $display("FAIL rd1_addr: got %h required 010081", fx_raddr); end
        vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL rd1_cmd_rdy: got %b required 0", cmd_rdy); end
        @(negedge clk_sys);
        vectors++; if (fx_rd !== 1'b0) begin miscompares++; $display("FAIL rd1_strobe_end: got %b required 0", fx_rd); end
        vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rd1_rsp_early: got %b required 0", rsp_vld); end
        @(negedge clk_sys);
        vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL rd1_rsp_vld: got %b required 1", rsp_vld); end
        vectors++; if (rsp_data !== 8'hA5) begin miscompares++; $display("FAIL rd1_rsp_data: got %h required a5", rsp_data); end
        @(negedge clk_sys);
        vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rd1_rsp_drop: got %b required 0", rsp_vld); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd1_busy_after: got %b required 0", busy); end
        idle_cycles(2);
        vectors++; if (rd_addr_q.size() !== 1) begin miscompares++; $display("FAIL rd1_count: got %0d required 1", rd_addr_q.size()); end
    endtask

    task automatic test_burst_write_wrap();
        logic [21:0] exp_a [4];
        logic [7:0]  exp_d [4];
        exp_a = '{22'h02FFFE, 22'h02FFFF, 22'h020000, 22'h020001};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        send_byte(8'h01); send_byte(8'hC2); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle_cycles(4);
        vectors++; if (wr_addr_q.size() !== 4) begin miscompares++; $display("FAIL bw_count: got %0d required 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            vectors++; if (wr_addr_q[i] !== exp_a[i]) begin miscompares++; $display("FAIL bw_addr[%0d]: got %h required %h", i, wr_addr_q[i], exp_a[i]); end
            vectors++; if (wr_data_q[i] !== exp_d[i]) begin miscompares++; $display("FAIL bw_data[%0d]: got %h required %h", i, wr_data_q[i], exp_d[i]); end
            if (i > 0) begin
                vectors++; if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 2) begin miscompares++; $display("FAIL bw_spacing[%0d]: got %0d required 2", i, wr_cyc_q[i] - wr_cyc_q[i-1]); end
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bw_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_burst_read_backpressure();
        logic [7:0] exp_d [3];
        int n;
        exp_d = '{8'h20, 8'h21, 8'h22};
        clear_log();
        rsp_rdy = 1'b1;
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            @(negedge clk_sys);
            while (rsp_vld !== 1'b1 && n < 20) begin @(negedge clk_sys); n++; end
            vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL br_rsp_timeout[%0d]: rsp_vld=%b required 1", i, rsp_vld); end
            vectors++; if (rsp_data !== exp_d[i]) begin miscompares++; $display("FAIL br_rsp_data[%0d]: got %h required %h", i, rsp_data, exp_d[i]); end
            if (i == 1) begin
                for (int k = 0; k < 5; k++) begin
                    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL br_stall_vld[%0d]: got %b required 1", k, rsp_vld); end
                    vectors++; if (rsp_data !== exp_d[1]) begin miscompares++; $display("FAIL br_stall_data[%0d]: got %h required %h", k, rsp_data, exp_d[1]); end
                    vectors++; if (fx_rd !== 1'b0) begin miscompares++; $display("FAIL br_stall_fx_rd[%0d]: got %b required 0", k, fx_rd); end
                    @(negedge clk_sys);
                end
                #1;
                rsp_rdy = 1'b1;
            end
            @(posedge clk_sys);
            #1;
            if (i == 0) rsp_rdy = 1'b0;
        end
        idle_cycles(4);
        vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL br_extra_rsp: got %b required 0", rsp_vld); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL br_busy_after: got %b required 0", busy); end
        vectors++; if (rd_addr_q.size() !== 3) begin miscompares++; $display("FAIL br_rd_count: got %0d required 3", rd_addr_q.size()); end
        for (int i = 0; i < 3 && i < rd_addr_q.size(); i++) begin
            vectors++; if (rd_addr_q[i] !== 22'h030010 + 22'(i)) begin miscompares++; $display("FAIL br_rd_addr[%0d]: got %h required %h", i, rd_addr_q[i], 22'h030010 + 22'(i)); end
        end
    endtask

    task automatic test_bad_opcode();
        clear_log();
        send_byte(8'h07);
        @(negedge clk_sys);
        vectors++; if (err_cmd !== 1'b1) begin miscompares++; $display("FAIL bad_err_pulse: got %b required 1", err_cmd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_busy: got %b required 0", busy); end
        @(negedge clk_sys);
        vectors++; if (err_cmd !== 1'b0) begin miscompares++; $display("FAIL bad_err_width: got %b required 0", err_cmd); end
        @(posedge clk_sys);
        #1;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
        @(negedge clk_sys);
        @(negedge clk_sys);
        @(negedge clk_sys);
        vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL bad_rd_vld: got %b required 1", rsp_vld); end
        vectors++; if (rsp_data !== 8'h15) begin miscompares++; $display("FAIL bad_rd_data: got %h required 15", rsp_data); end
        idle_cycles(3);
        vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL bad_err_count: got %0d required 1", err_cnt); end
        vectors++; if (wr_addr_q.size() !== 0) begin miscompares++; $display("FAIL bad_wr_count: got %0d required 0", wr_addr_q.size()); end
        vectors++; if (rd_addr_q.size() !== 1) begin miscompares++; $display("FAIL bad_rd_count: got %0d required 1", rd_addr_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        clear_log();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk_sys);
        vectors++; if (fx_wr !== 1'b1) begin miscompares++; $display("FAIL rmb_second_wr: got %b required 1", fx_wr); end
        @(posedge clk_sys);
        #1;
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        @(negedge clk_sys);
        vectors++; if (fx_wr !== 1'b0) begin miscompares++; $display("FAIL rmb_fx_wr: got %b required 0", fx_wr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmb_busy: got %b required 0", busy); end
        vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL rmb_cmd_rdy: got %b required 1", cmd_rdy); end
        idle_cycles(5);
        vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL rmb_wr_count: got %0d required 2", wr_addr_q.size()); end
        clear_log();
        send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h77);
        @(negedge clk_sys);
        vectors++; if (fx_wr !== 1'b1) begin miscompares++; $display("FAIL rmb_new_wr: got %b required 1", fx_wr); end
        vectors++; if (fx_waddr !== 22'h050000) begin miscompares++; $display("FAIL rmb_new_addr: got %h required 050000", fx_waddr); end
        vectors++; if (fx_data !== 8'h77) begin miscompares++; $display("FAIL rmb_new_data: got %h required 77", fx_data); end
        idle_cycles(3);
    endtask

    task automatic test_exclusive_strobes();
        vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d cycles required 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write_wrap();
        test_burst_read_backpressure();
        test_bad_opcode();
        test_reset_mid_burst();
        test_exclusive_strobes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fx_bus_master.md
# fx_bus_master

Byte-stream to fx bus initiator: it parses command packets from a host byte stream and issues single-cycle `fx_wr` / `fx_rd` transactions on the fx register bus. Each read returns `fx_q` as a byte on a response stream. It sits between the host link (USB/UART byte FIFO) and the per-device register slaves. Slaves decode `addr[21:16]` as device id and drive `fx_q` to 0 when not selected, so their outputs are OR-combined into `fx_q`.

## Interface
- `RD_LAT`, default 1: cycles from the `fx_rd` cycle to the cycle `fx_q` is valid (legal 1–3).

Ports:
- `clk_sys`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_data`, in, 8: command byte.
- `cmd_vld`, in, 1: command byte valid.
- `cmd_rdy`, out, 1: block accepts a command byte.
- `rsp_data`, out, 8: read response byte.
- `rsp_vld`, out, 1: response valid.
- `rsp_rdy`, in, 1: response consumer ready.
- `fx_waddr`, out, 22: write address, `[21:16]` = device id.
- `fx_wr`, out, 1: write strobe, 1 cycle.
- `fx_data`, out, 8: write data.
- `fx_raddr`, out, 22: read address.
- `fx_rd`, out, 1: read strobe, 1 cycle.
- `fx_q`, in, 8: OR-combined slave read data.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `err_cmd`, out, 1: one-cycle pulse for an unknown opcode.

## Operation
- Packet format: OP, A2, A1, A0, LEN, then for writes N data bytes.
  - OP: 0x01 = write, 0x02 = read.
  - Address = {A2[5:0], A1, A0}; A2[7:6] are ignored.
  - N = LEN+1, range 1–256.
- A byte is accepted on a cycle where `cmd_vld & cmd_rdy`.
- `cmd_rdy` = 1 in IDLE, ADR2, ADR1, ADR0, LEN and WDAT; 0 in all other states.
- FSM states: IDLE, ADR2, ADR1, ADR0, LEN, WDAT, WR, RD, RWAIT, RSP.
  - IDLE: OP accepted. Write or read goes to ADR2. Any other value: byte discarded, `err_cmd` pulses the next cycle, stay IDLE.
  - ADR2 → ADR1 → ADR0 → LEN: one accepted byte each.
  - LEN: loads the remaining count N. Write goes to WDAT; read goes to RD.
  - WDAT: data byte accepted → WR.
  - WR: `fx_wr`=1 with `fx_waddr`=addr and `fx_data`=byte for exactly one cycle. Then addr increments and count decrements. Count>0 → WDAT, else IDLE.
  - RD: `fx_rd`=1 with `fx_raddr`=addr for exactly one cycle → RWAIT.
  - RWAIT: lasts RD_LAT cycles. `fx_q` is captured into `rsp_data` on its last cycle → RSP.
  - RSP: `rsp_vld`=1 and `rsp_data` held stable until `rsp_rdy`. On the handshake: addr increments, count decrements; count>0 → RD, else IDLE.
- Address increment: `addr[15:0]` = (`addr[15:0]`+1) mod 2^16; `addr[21:16]` never changes (wrap stays within the device).
- `fx_wr` and `fx_rd` are never high in the same cycle.
- Only one fx transaction is outstanding at a time.
- All outputs are registered.

## Timing
- Reset values: state IDLE; `fx_wr`, `fx_rd`, `rsp_vld`, `err_cmd`, `busy` = 0; `fx_waddr`, `fx_raddr` = 22'h0; `fx_data`, `rsp_data` = 8'h0. `cmd_rdy` = 1 from the first cycle after reset.
- Write latency: data byte accepted in cycle t → `fx_wr` high in cycle t+1. Next data byte is accepted no earlier than t+2, so peak rate is one write per 2 cycles.
- Read latency: `fx_rd` high in cycle t; `fx_q` sampled in cycle t+RD_LAT; `rsp_vld` high from t+RD_LAT+1. With `rsp_rdy` held high, the next `fx_rd` occurs at t+RD_LAT+2.
- Idle bus: `fx_wr`/`fx_rd` = 0; address and data outputs hold their last driven value.
- Stalls: `cmd_vld` low mid-packet leaves the FSM waiting indefinitely; there is no timeout. `rsp_rdy` low holds RSP indefinitely, with no further bus traffic.
- Reset mid-operation: the FSM returns to IDLE on the next edge and the partial packet is dropped. `fx_wr`, `fx_rd`, `rsp_vld` are 0 in the cycle after `rst`.

## Test plan
- Single write: stream 01,01,00,80,00,3C → exactly one cycle with `fx_wr`=1, `fx_waddr`=22'h010080, `fx_data`=8'h3C. `busy` returns 0 the cycle after.
- Single read, RD_LAT=1: slave model returns 8'hA5 one cycle after `fx_rd`. Stream 02,01,00,81,00 → one `fx_rd` pulse at `fx_raddr`=22'h010081, then `rsp_vld` with `rsp_data`=8'hA5 two cycles later.
- Burst write with wrap: 01,C2,FF,FE,03 plus data 11,22,33,44 → writes to 22'h02FFFE, 02FFFF, 020000, 020001 with data 11/22/33/44. A2 bits [7:6] are ignored.
- Burst read with backpressure: 3-byte read with `rsp_rdy` low for 5 cycles on byte 2 → `rsp_data` holds stable, no `fx_rd` during the stall, exactly 3 responses in address order.
- Bad opcode: stream 07, then a valid single read → one `err_cmd` pulse, no bus activity for 07, and the read completes normally.
- Reset mid-burst: assert `rst` for 1 cycle after the 2nd write of a 4-byte burst → no further `fx_wr`. A new packet then executes correctly from IDLE.
